// File: rtl/id_ex_stage_reg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_reg
//
// ID/EX pipeline register. Captures the decoded control bundle and operands
// into EX, inserts a one-cycle bubble on a load-use hazard, holds a multiply
// in EX for MUL_CYCLES cycles while stalling upstream, and kills the held or
// incoming instruction on a branch/jump flush from EX.
//
// Optional feature macro: BUBBLE_COUNT_EN
//   defined   -> BubbleCount is a 16-bit saturating count of bubbles latched
//                because of a load-use hazard or a flush.
//   undefined -> BubbleCount is tied to zero and no counter flops exist.
//
// Parameters
//   MUL_CYCLES    cycles a multiply occupies EX (legal 1..16)
//
// Ports
//   Clk           system clock, rising edge
//   Rst           asynchronous reset, active-high
//   Flush         kill the instruction entering/held in ID/EX
//   In_Ctrl[9:0]  {RegDst,RegWrite,AluSrc,MemWrite,MemRead,Branch,
//                  MemToReg,SignExt,Jump,JumpMux}
//   In_AluOp      ALU operation code
//   In_ReadData1  rs value
//   In_ReadData2  rt value
//   In_Imm        extended immediate
//   In_PCPlus4    PC+4 of the decoding instruction
//   In_Rs/Rt/Rd   register index fields
//   Out_*         registered copies of In_*
//   Stall         hold PC and IF/ID this cycle (combinational)
//   BubbleCount   bubbles inserted (see BUBBLE_COUNT_EN)
// -----------------------------------------------------------------------------
module id_ex_stage_reg #(
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Flush,
  input  logic [9:0]  In_Ctrl,
  input  logic [3:0]  In_AluOp,
  input  logic [31:0] In_ReadData1,
  input  logic [31:0] In_ReadData2,
  input  logic [31:0] In_Imm,
  input  logic [31:0] In_PCPlus4,
  input  logic [4:0]  In_Rs,
  input  logic [4:0]  In_Rt,
  input  logic [4:0]  In_Rd,
  output logic [9:0]  Out_Ctrl,
  output logic [3:0]  Out_AluOp,
  output logic [31:0] Out_ReadData1,
  output logic [31:0] Out_ReadData2,
  output logic [31:0] Out_Imm,
  output logic [31:0] Out_PCPlus4,
  output logic [4:0]  Out_Rs,
  output logic [4:0]  Out_Rt,
  output logic [4:0]  Out_Rd,
  output logic        Stall,
  output logic [15:0] BubbleCount
);

  // Control-bundle bit positions
  localparam int CTRL_REG_WRITE = 8;
  localparam int CTRL_MEM_READ  = 5;

  localparam logic [3:0] ALUOP_MUL    = 4'b1100;
  localparam logic [3:0] ALUOP_BUBBLE = 4'b0001;

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MUL_WAIT = 1'b1;

  // A single-cycle multiply never enters MUL_WAIT.
  localparam bit         MUL_MULTI    = (MUL_CYCLES > 1);
  localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_CYCLES - 1);

  logic [0:0]  r_state;
  logic [3:0]  r_cnt;

  logic [9:0]  r_ctrl;
  logic [3:0]  r_aluop;
  logic [31:0] r_rd1;
  logic [31:0] r_rd2;
  logic [31:0] r_imm;
  logic [31:0] r_pc4;
  logic [4:0]  r_rs;
  logic [4:0]  r_rt;
  logic [4:0]  r_rd;

  logic w_load_use;
  logic w_in_run;
  logic w_take_bubble;
  logic w_load;

  // Hazard: the instruction now in EX is a load writing a register that the
  // decoding instruction reads. $0 is never a real dependency.
  assign w_load_use = r_ctrl[CTRL_MEM_READ] & r_ctrl[CTRL_REG_WRITE] &
                      (r_rt != 5'd0) &
                      ((r_rt == In_Rs) | (r_rt == In_Rt));

  assign w_in_run = (r_state == ST_RUN);

  // Flush outranks the multiply hold; the load-use check applies only in RUN
  // because a held multiply never reads memory.
  assign w_take_bubble = Flush | (w_in_run & w_load_use);
  assign w_load        = ~w_take_bubble & w_in_run;

  assign Stall = ~Flush & (~w_in_run | w_load_use);

  // Pipeline payload. Anything other than a bubble or a load is a hold.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_ctrl  <= '0;
      r_aluop <= ALUOP_BUBBLE;
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_imm   <= '0;
      r_pc4   <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_rd    <= '0;
    end else if (w_take_bubble) begin
      r_ctrl  <= '0;
      r_aluop <= ALUOP_BUBBLE;
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_imm   <= '0;
      r_pc4   <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_rd    <= '0;
    end else if (w_load) begin
      r_ctrl  <= In_Ctrl;
      r_aluop <= In_AluOp;
      r_rd1   <= In_ReadData1;
      r_rd2   <= In_ReadData2;
      r_imm   <= In_Imm;
      r_pc4   <= In_PCPlus4;
      r_rs    <= In_Rs;
      r_rt    <= In_Rt;
      r_rd    <= In_Rd;
    end
  end

  // Multiply occupancy. The counter counts down the remaining stall cycles;
  // leaving MUL_WAIT on cnt==1 gives MUL_CYCLES-1 stalled cycles in total.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= ST_RUN;
      r_cnt   <= 4'd0;
    end else if (Flush) begin
      r_state <= ST_RUN;
      r_cnt   <= 4'd0;
    end else if (r_state == ST_MUL_WAIT) begin
      r_cnt <= r_cnt - 4'd1;
      if (r_cnt == 4'd1) begin
        r_state <= ST_RUN;
      end
    end else if (!w_load_use && (In_AluOp == ALUOP_MUL) && MUL_MULTI) begin
      r_state <= ST_MUL_WAIT;
      r_cnt   <= MUL_CNT_INIT;
    end
  end

`ifdef BUBBLE_COUNT_EN
  logic [15:0] r_bubble_cnt;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_bubble_cnt <= 16'd0;
    end else if (w_take_bubble && (r_bubble_cnt != 16'hFFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end

  assign BubbleCount = r_bubble_cnt;
`else
  assign BubbleCount = 16'h0000;
`endif

  assign Out_Ctrl      = r_ctrl;
  assign Out_AluOp     = r_aluop;
  assign Out_ReadData1 = r_rd1;
  assign Out_ReadData2 = r_rd2;
  assign Out_Imm       = r_imm;
  assign Out_PCPlus4   = r_pc4;
  assign Out_Rs        = r_rs;
  assign Out_Rt        = r_rt;
  assign Out_Rd        = r_rd;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage_reg
//
// Directed bench for id_ex_stage_reg. Expected EX contents are pushed to a
// scoreboard queue as each instruction is driven and popped after the edge
// that should produce them. Honours BUBBLE_COUNT_EN for BubbleCount checks.
// -----------------------------------------------------------------------------
module tb_id_ex_stage_reg;

  localparam int unsigned MUL_CYCLES = 4;

`ifdef BUBBLE_COUNT_EN
  localparam bit BC_EN = 1'b1;
`else
  localparam bit BC_EN = 1'b0;
`endif

  typedef struct packed {
    logic [9:0]  ctrl;
    logic [3:0]  aluop;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } stage_t;

  logic        Clk;
  logic        Rst;
  logic        Flush;
  logic [9:0]  In_Ctrl;
  logic [3:0]  In_AluOp;
  logic [31:0] In_ReadData1;
  logic [31:0] In_ReadData2;
  logic [31:0] In_Imm;
  logic [31:0] In_PCPlus4;
  logic [4:0]  In_Rs;
  logic [4:0]  In_Rt;
  logic [4:0]  In_Rd;
  logic [9:0]  Out_Ctrl;
  logic [3:0]  Out_AluOp;
  logic [31:0] Out_ReadData1;
  logic [31:0] Out_ReadData2;
  logic [31:0] Out_Imm;
  logic [31:0] Out_PCPlus4;
  logic [4:0]  Out_Rs;
  logic [4:0]  Out_Rt;
  logic [4:0]  Out_Rd;
  logic        Stall;
  logic [15:0] BubbleCount;

  id_ex_stage_reg #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .Flush         (Flush),
    .In_Ctrl       (In_Ctrl),
    .In_AluOp      (In_AluOp),
    .In_ReadData1  (In_ReadData1),
    .In_ReadData2  (In_ReadData2),
    .In_Imm        (In_Imm),
    .In_PCPlus4    (In_PCPlus4),
    .In_Rs         (In_Rs),
    .In_Rt         (In_Rt),
    .In_Rd         (In_Rd),
    .Out_Ctrl      (Out_Ctrl),
    .Out_AluOp     (Out_AluOp),
    .Out_ReadData1 (Out_ReadData1),
    .Out_ReadData2 (Out_ReadData2),
    .Out_Imm       (Out_Imm),
    .Out_PCPlus4   (Out_PCPlus4),
    .Out_Rs        (Out_Rs),
    .Out_Rt        (Out_Rt),
    .Out_Rd        (Out_Rd),
    .Stall         (Stall),
    .BubbleCount   (BubbleCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int     n_cmp  = 0;
  int     n_fail = 0;
  int     exp_bc = 0;
  stage_t sb[$];

  function automatic stage_t mk(input logic [9:0] ctrl, input logic [3:0] aluop,
                                input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic [31:0] imm, input logic [31:0] pc,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd);
    stage_t s;
    s.ctrl = ctrl; s.aluop = aluop; s.rd1 = rd1; s.rd2 = rd2;
    s.imm = imm; s.pc = pc; s.rs = rs; s.rt = rt; s.rd = rd;
    return s;
  endfunction

  // Bubble values built independently of the DUT.
  function automatic stage_t bubble();
    return mk(10'b0, 4'b0001, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
  endfunction

  function automatic stage_t sample();
    return mk(Out_Ctrl, Out_AluOp, Out_ReadData1, Out_ReadData2, Out_Imm,
              Out_PCPlus4, Out_Rs, Out_Rt, Out_Rd);
  endfunction

  task automatic drive(input stage_t v);
    In_Ctrl      = v.ctrl;
    In_AluOp     = v.aluop;
    In_ReadData1 = v.rd1;
    In_ReadData2 = v.rd2;
    In_Imm       = v.imm;
    In_PCPlus4   = v.pc;
    In_Rs        = v.rs;
    In_Rt        = v.rt;
    In_Rd        = v.rd;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_out(input string tag);
    stage_t e;
    stage_t o;
    n_cmp++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, sample());
    end else begin
      e = sb.pop_front();
      o = sample();
      assert (o === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
    end
  endtask

  task automatic chk_stall(input string tag, input logic e);
    n_cmp++;
    assert (Stall === e) else begin
      n_fail++;
      $error("FAIL %s: Stall observed %b expected %b", tag, Stall, e);
    end
  endtask

  task automatic chk_bc(input string tag);
    logic [15:0] e;
    e = BC_EN ? 16'(exp_bc) : 16'h0000;
    n_cmp++;
    assert (BubbleCount === e) else begin
      n_fail++;
      $error("FAIL %s: BubbleCount observed %0d expected %0d", tag, BubbleCount, e);
    end
  endtask

  // Control bundles: {RegDst,RegWrite,AluSrc,MemWrite,MemRead,Branch,MemToReg,SignExt,Jump,JumpMux}
  localparam logic [9:0] C_ADDI = 10'b1110000100;
  localparam logic [9:0] C_LW   = 10'b0110101100;
  localparam logic [9:0] C_RTYP = 10'b1100000000;

  initial begin
    stage_t addi, lw8, add8, lw0, add0, mul_a, nxt, lw12, sw12, lw13, dep13, mul_b;

    addi  = mk(C_ADDI, 4'b0001, 32'd5, 32'd0, 32'd3, 32'h0000_0004, 5'd1, 5'd2, 5'd0);
    lw8   = mk(C_LW,   4'b0001, 32'h100, 32'd0, 32'd8, 32'h0000_0008, 5'd9, 5'd8, 5'd0);
    add8  = mk(C_RTYP, 4'b0010, 32'd11, 32'd22, 32'd0, 32'h0000_000C, 5'd8, 5'd10, 5'd11);
    lw0   = mk(C_LW,   4'b0001, 32'h200, 32'd0, 32'd4, 32'h0000_0010, 5'd3, 5'd0, 5'd0);
    add0  = mk(C_RTYP, 4'b0010, 32'd0, 32'd0, 32'd0, 32'h0000_0014, 5'd0, 5'd0, 5'd12);
    mul_a = mk(C_RTYP, 4'b1100, 32'd7, 32'd6, 32'd0, 32'h0000_0018, 5'd4, 5'd5, 5'd6);
    nxt   = mk(C_RTYP, 4'b0010, 32'hAAAA_5555, 32'h1234_5678, 32'd0, 32'h0000_001C, 5'd14, 5'd15, 5'd16);
    lw12  = mk(C_LW,   4'b0001, 32'h300, 32'd0, 32'd0, 32'h0000_0020, 5'd1, 5'd12, 5'd0);
    sw12  = mk(C_RTYP, 4'b0010, 32'd1, 32'd2, 32'd0, 32'h0000_0024, 5'd1, 5'd12, 5'd17);
    lw13  = mk(C_LW,   4'b0001, 32'h400, 32'd0, 32'd0, 32'h0000_0028, 5'd2, 5'd13, 5'd0);
    dep13 = mk(C_RTYP, 4'b0010, 32'd3, 32'd4, 32'd0, 32'h0000_002C, 5'd13, 5'd2, 5'd18);
    mul_b = mk(C_RTYP, 4'b1100, 32'd9, 32'd9, 32'd0, 32'h0000_0030, 5'd19, 5'd20, 5'd21);

    // Reset
    Rst   = 1'b1;
    Flush = 1'b0;
    drive(bubble());
    #11;
    sb.push_back(bubble());
    chk_out("reset_out");
    chk_stall("reset_stall", 1'b0);
    chk_bc("reset_bc");
    #1;
    Rst = 1'b0;

    // ADDI passes through in one cycle
    drive(addi);
    sb.push_back(addi);
    #1;
    chk_stall("addi_stall", 1'b0);
    tick();
    chk_out("addi_out");

    // Load-use through rs: one bubble, then the dependent instruction loads
    drive(lw8);
    sb.push_back(lw8);
    #1;
    chk_stall("lw8_stall", 1'b0);
    tick();
    chk_out("lw8_out");
    drive(add8);
    #1;
    chk_stall("lu_rs_stall", 1'b1);
    sb.push_back(bubble());
    exp_bc++;
    tick();
    chk_out("lu_rs_bubble");
    chk_bc("lu_rs_bc");
    chk_stall("lu_rs_cleared", 1'b0);
    sb.push_back(add8);
    tick();
    chk_out("lu_rs_add_out");

    // Load to $0 is not a hazard
    drive(lw0);
    sb.push_back(lw0);
    tick();
    chk_out("lw0_out");
    drive(add0);
    #1;
    chk_stall("lw0_nostall", 1'b0);
    sb.push_back(add0);
    tick();
    chk_out("lw0_add_out");

    // Load-use through rt
    drive(lw12);
    sb.push_back(lw12);
    tick();
    chk_out("lw12_out");
    drive(sw12);
    #1;
    chk_stall("lu_rt_stall", 1'b1);
    sb.push_back(bubble());
    exp_bc++;
    tick();
    chk_out("lu_rt_bubble");
    sb.push_back(sw12);
    tick();
    chk_out("lu_rt_out");
    chk_bc("lu_rt_bc");

    // Flush in RUN during a load-use hazard: single bubble, no stall
    drive(lw13);
    sb.push_back(lw13);
    tick();
    chk_out("lw13_out");
    drive(dep13);
    Flush = 1'b1;
    #1;
    chk_stall("flush_lu_stall", 1'b0);
    sb.push_back(bubble());
    exp_bc++;
    tick();
    Flush = 1'b0;
    chk_out("flush_lu_bubble");
    chk_bc("flush_lu_bc");
    sb.push_back(dep13);
    #1;
    chk_stall("flush_lu_after", 1'b0);
    tick();
    chk_out("flush_lu_dep_out");

    // Multiply: MUL_CYCLES-1 stall cycles with EX held, then next loads
    drive(mul_a);
    sb.push_back(mul_a);
    tick();
    chk_out("mul_latch");
    drive(nxt);
    for (int i = 0; i < int'(MUL_CYCLES) - 1; i++) begin
      #1;
      chk_stall($sformatf("mul_stall_%0d", i), 1'b1);
      sb.push_back(mul_a);
      tick();
      chk_out($sformatf("mul_hold_%0d", i));
    end
    chk_stall("mul_done_stall", 1'b0);
    sb.push_back(nxt);
    tick();
    chk_out("mul_next_out");

    // Flush during the second MUL_WAIT cycle
    drive(mul_a);
    sb.push_back(mul_a);
    tick();
    chk_out("mulf_latch");
    drive(nxt);
    chk_stall("mulf_wait1_stall", 1'b1);
    tick();
    Flush = 1'b1;
    #1;
    chk_stall("mulf_flush_stall", 1'b0);
    sb.push_back(bubble());
    exp_bc++;
    tick();
    Flush = 1'b0;
    chk_out("mulf_bubble");
    chk_bc("mulf_bc");
    #1;
    chk_stall("mulf_run_stall", 1'b0);
    sb.push_back(nxt);
    tick();
    chk_out("mulf_next_out");

    // Reset mid-multiply (cnt==2), then a fresh multiply waits a full window
    drive(mul_a);
    sb.push_back(mul_a);
    tick();
    chk_out("mulr_latch");
    drive(nxt);
    tick();
    Rst = 1'b1;
    #1;
    sb.push_back(bubble());
    exp_bc = 0;
    chk_out("mulr_reset_out");
    chk_stall("mulr_reset_stall", 1'b0);
    chk_bc("mulr_reset_bc");
    Rst = 1'b0;
    drive(mul_b);
    sb.push_back(mul_b);
    #1;
    chk_stall("mulr_new_stall0", 1'b0);
    tick();
    chk_out("mulr_new_latch");
    drive(nxt);
    for (int i = 0; i < int'(MUL_CYCLES) - 1; i++) begin
      chk_stall($sformatf("mulr_stall_%0d", i), 1'b1);
      sb.push_back(mul_b);
      tick();
      chk_out($sformatf("mulr_hold_%0d", i));
    end
    chk_stall("mulr_done_stall", 1'b0);
    sb.push_back(nxt);
    tick();
    chk_out("mulr_next_out");
    chk_bc("final_bc");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
